ddr3_app_responder: RTL and testbench
=====================================

# ddr3_app_responder

Synthesizable, BRAM-backed responder for the 7-series MIG user (app) interface, 32-bit data path. It stands in for the MIG core plus DDR3 device, so the app-interface initiator and the ppfifo/DDR3 datapath can be simulated and run on boards without external memory. Each command moves one 64-bit burst: two 32-bit beats.

## Interface
Parameters:
- MEM_ADDR_DEPTH, 28: width of i_app_addr.
- RAM_ADDR_BITS, 10: log2 of the number of 64-bit bursts stored (default 1024 bursts = 8 KiB).
- CALIB_CYCLES, 64: cycles from reset release to calibration complete; must be ≥1.
- READ_LATENCY, 8: command-accept to first read beat, in cycles; must be ≥2.
- WDF_DEPTH, 8: write-data FIFO depth in beats; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- o_init_calib_complete  out  1  high once calibration delay elapses.
- o_app_rdy  out  1  command accept.
- o_app_wdf_rdy  out  1  write-data accept.
- i_app_en  in  1  command valid.
- i_app_cmd  in  3  3'b000 write, 3'b001 read.
- i_app_addr  in  MEM_ADDR_DEPTH  byte address; bits [2:0] ignored.
- i_app_wdf_wren  in  1  write beat valid.
- i_app_wdf_mask  in  4  bit n=1 ⇒ byte n NOT written.
- i_app_wdf_end  in  1  last beat of burst.
- i_app_wdf_data  in  32  write beat.
- o_app_rd_data_valid  out  1  read beat valid.
- o_app_rd_data_end  out  1  second read beat.
- o_app_rd_data  out  32  read beat.
- i_stall  in  1  test hook; forces o_app_rdy low.
- o_err  out  2  sticky: [0] unsupported cmd, [1] wdf_end misaligned.

## Operation
- Burst index = i_app_addr[RAM_ADDR_BITS+2:3]; upper bits alias. Beat0 = word {idx,0}, beat1 = word {idx,1}.
- Write-data FIFO: beat pushed when i_app_wdf_wren && o_app_wdf_rdy. o_app_wdf_rdy = calib && !fifo_full. Data may precede its command by up to WDF_DEPTH beats.
- Command accept: i_app_en && o_app_rdy. o_app_rdy = calib && !i_stall && state==IDLE.
- FSM: IDLE, WR_WAIT, WR_BEAT0, WR_BEAT1, RD_BEAT0, RD_BEAT1.
  - IDLE: accept write ⇒ latch idx, go WR_WAIT. Accept read ⇒ RD_BEAT0. Any other cmd is dropped, sets o_err[0], stays IDLE.
  - WR_WAIT: go WR_BEAT0 when FIFO holds ≥2 beats.
  - WR_BEAT0/WR_BEAT1: pop one beat each, byte-masked RAM write; then IDLE.
  - RD_BEAT0/RD_BEAT1: read RAM word and push {data, valid, end} into the latency pipe; end=1 on beat1. Then IDLE.
- o_err[1] set when a beat popped as beat0 carries wdf_end=1, or a beat1 carries wdf_end=0.
- Commands execute strictly in order. A read accepted after a write returns the written data.
- No refresh, no reordering.

## Timing
- Reset: all outputs 0, FSM IDLE, FIFO flushed, latency pipe cleared, calib counter restarts, o_err cleared; RAM contents kept.
- o_init_calib_complete rises at cycle CALIB_CYCLES after the first cycle with rst low.
- Read accepted at cycle T ⇒ beat0 valid at T+READ_LATENCY, beat1 (with end) at T+READ_LATENCY+1.
- o_app_rdy is low in every non-IDLE state. Minimum command spacing: read 3 cycles; write 4 cycles when data is already buffered.
- A write in RAM is visible to a read accepted on the cycle the FSM returns to IDLE.
- FIFO full: o_app_wdf_rdy low on the same cycle count reaches WDF_DEPTH. A pop and a push in the same cycle are both honored.
- i_stall only gates o_app_rdy. In-flight bursts and the read pipe continue.
- Reset mid-burst: in-flight read beats are discarded. A partial write leaves RAM with at most beat0 updated.

## Structure
- Package ddr3_app_pkg: CMD_WR, CMD_RD, state encoding, error bit indices; shared with the app-interface initiator.
- Sub-module ddr3_wdf_fifo: synchronous FIFO, 37-bit entries {end, mask, data}, count output.
- RAM: inferred true dual-port BRAM, 2^(RAM_ADDR_BITS+1)×32, with per-byte write enables.

## Test plan
- Calibration: release rst ⇒ o_init_calib_complete=0 through cycle 63, 1 at cycle 64; o_app_rdy/o_app_wdf_rdy stay 0 until then.
- Write then read: write addr 0x40, data 0x11223344/0x55667788, mask 0 ⇒ read of 0x40 returns both words, valid at T+8 and T+9, end on the second.
- Byte mask: prefill 0xFFFFFFFF; write 0x00000000 with mask 4'b0101 ⇒ readback 0x00FF00FF.
- Data before command: push 8 beats (4 bursts) with no command ⇒ wdf_rdy drops; then issue 4 write commands ⇒ all four bursts stored correctly, wdf_rdy returns.
- Backpressure and aliasing: i_stall held 20 cycles ⇒ command held, no beats popped. A write to burst 1024 reads back at burst 0.
- Errors/reset: cmd 3'b010 ⇒ o_err=2'b01, no RAM change. Misplaced wdf_end ⇒ o_err[1]=1. rst during a read ⇒ no rd_data_valid afterwards, o_err=0.

Source files
------------

// File: rtl/ddr3_app_pkg.sv
// Shared definitions for the 7-series MIG user (app) interface at a 32-bit
// data path. Used by the BRAM-backed responder and by the app-interface
// initiator.
//   CMD_WR / CMD_RD : app_cmd encodings
//   ERR_*           : bit positions in the responder's sticky error vector
//   app_state_e     : responder command FSM states
//   wdf_entry_t     : one write-data FIFO entry {end, mask, data} (37 bits)
//   rd_beat_t       : one read-latency pipe entry {valid, end, data}
package ddr3_app_pkg;

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    localparam int unsigned ERR_CMD     = 0;
    localparam int unsigned ERR_WDF_END = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_WAIT,
        ST_WR_BEAT0,
        ST_WR_BEAT1,
        ST_RD_BEAT0,
        ST_RD_BEAT1
    } app_state_e;

    typedef struct packed {
        logic        last;
        logic [3:0]  mask;
        logic [31:0] data;
    } wdf_entry_t;

    typedef struct packed {
        logic        valid;
        logic        last;
        logic [31:0] data;
    } rd_beat_t;

endpackage

// File: rtl/ddr3_app_responder_if.sv
// MIG app-interface signal bundle (32-bit data path).
// Signal names keep the responder's original port names: i_* are driven by
// the initiator, o_* by the responder.
//   master : initiator side (drives i_*, observes o_*)
//   slave  : responder side (drives o_*, observes i_*)
// i_stall is a test hook that only gates o_app_rdy.
interface ddr3_app_responder_if #(
    parameter int unsigned MEM_ADDR_DEPTH = 28
) ();

    logic                      o_init_calib_complete;
    logic                      o_app_rdy;
    logic                      o_app_wdf_rdy;
    logic                      i_app_en;
    logic [2:0]                i_app_cmd;
    logic [MEM_ADDR_DEPTH-1:0] i_app_addr;
    logic                      i_app_wdf_wren;
    logic [3:0]                i_app_wdf_mask;
    logic                      i_app_wdf_end;
    logic [31:0]               i_app_wdf_data;
    logic                      o_app_rd_data_valid;
    logic                      o_app_rd_data_end;
    logic [31:0]               o_app_rd_data;
    logic                      i_stall;
    logic [1:0]                o_err;

    modport master (
        input  o_init_calib_complete, o_app_rdy, o_app_wdf_rdy,
        input  o_app_rd_data_valid, o_app_rd_data_end, o_app_rd_data, o_err,
        output i_app_en, i_app_cmd, i_app_addr,
        output i_app_wdf_wren, i_app_wdf_mask, i_app_wdf_end, i_app_wdf_data,
        output i_stall
    );

    modport slave (
        output o_init_calib_complete, o_app_rdy, o_app_wdf_rdy,
        output o_app_rd_data_valid, o_app_rd_data_end, o_app_rd_data, o_err,
        input  i_app_en, i_app_cmd, i_app_addr,
        input  i_app_wdf_wren, i_app_wdf_mask, i_app_wdf_end, i_app_wdf_data,
        input  i_stall
    );

endinterface

// File: rtl/ddr3_wdf_fifo.sv
// Synchronous write-data FIFO holding {end, mask, data} beats.
//   clk, rst : clock, synchronous active-high reset (flushes the FIFO)
//   i_push   : write i_entry (ignored when full)
//   i_pop    : drop the head entry (ignored when empty)
//   o_head   : current head entry (valid when !o_empty)
//   o_count  : number of entries held, 0..DEPTH
//   o_full / o_empty : occupancy flags
// DEPTH must be a power of 2 so the pointers wrap naturally.
module ddr3_wdf_fifo
    import ddr3_app_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_push,
    input  wdf_entry_t             i_entry,
    input  logic                   i_pop,
    output wdf_entry_t             o_head,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                   o_full,
    output logic                   o_empty
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned CNT_W = AW + 1;

    wdf_entry_t       mem_q [DEPTH];
    wdf_entry_t       mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign o_full  = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign o_count = count_q;
    assign o_head  = mem_q[rd_ptr_q];

    assign push_ok = i_push && !o_full;
    assign pop_ok  = i_pop && !o_empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = i_entry;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage is not reset: the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ddr3_app_responder.sv
// BRAM-backed stand-in for the 7-series MIG core plus DDR3 device, 32-bit app
// data path. Each command moves one 64-bit burst (two 32-bit beats).
//   clk, rst : clock, synchronous active-high reset (RAM contents survive)
//   app      : app-interface bundle, slave side
//     o_init_calib_complete : high CALIB_CYCLES cycles after reset release
//     o_app_rdy / i_app_en / i_app_cmd / i_app_addr : command handshake
//     o_app_wdf_rdy / i_app_wdf_* : write-data handshake into a FIFO
//     o_app_rd_data_valid / _end / o_app_rd_data : read beats, READ_LATENCY
//       cycles after command accept
//     i_stall : holds o_app_rdy low
//     o_err   : sticky [0] unsupported command, [1] misplaced wdf_end
module ddr3_app_responder
    import ddr3_app_pkg::*;
#(
    parameter int unsigned MEM_ADDR_DEPTH = 28,
    parameter int unsigned RAM_ADDR_BITS  = 10,
    parameter int unsigned CALIB_CYCLES   = 64,
    parameter int unsigned READ_LATENCY   = 8,
    parameter int unsigned WDF_DEPTH      = 8
) (
    input logic                 clk,
    input logic                 rst,
    ddr3_app_responder_if.slave app
);

    localparam int unsigned CAL_W       = $clog2(CALIB_CYCLES) + 1;
    localparam int unsigned CNT_W       = $clog2(WDF_DEPTH) + 1;
    localparam int unsigned WORD_AW     = RAM_ADDR_BITS + 1;
    localparam int unsigned PIPE_STAGES = READ_LATENCY - 2;

    // ---------------- calibration delay ----------------
    logic [CAL_W-1:0] calib_cnt_q, calib_cnt_d;
    logic             calib_q, calib_d;

    always_comb begin
        calib_cnt_d = calib_cnt_q;
        calib_d     = calib_q;
        if (!calib_q) begin
            calib_cnt_d = calib_cnt_q + 1'b1;
            if (calib_cnt_q == CAL_W'(CALIB_CYCLES - 1)) begin
                calib_d = 1'b1;
            end
        end
    end

    // ---------------- write-data FIFO ----------------
    wdf_entry_t       wdf_in, fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_full, fifo_empty, fifo_pop, wdf_rdy;

    assign wdf_rdy = calib_q && !fifo_full;
    assign wdf_in  = {app.i_app_wdf_end, app.i_app_wdf_mask, app.i_app_wdf_data};

    ddr3_wdf_fifo #(.DEPTH(WDF_DEPTH)) u_wdf_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (app.i_app_wdf_wren && wdf_rdy),
        .i_entry (wdf_in),
        .i_pop   (fifo_pop),
        .o_head  (fifo_head),
        .o_count (fifo_count),
        .o_full  (fifo_full),
        .o_empty (fifo_empty)
    );

    // ---------------- command FSM ----------------
    app_state_e               state_q, state_d;
    logic [RAM_ADDR_BITS-1:0] idx_q, idx_d;
    logic [1:0]               err_q, err_d;
    logic                     rd_valid_q, rd_valid_d;
    logic                     rd_last_q, rd_last_d;
    logic [MEM_ADDR_DEPTH-1:0] app_addr;
    logic [RAM_ADDR_BITS-1:0] burst_idx;
    logic                     app_rdy, cmd_fire, ram_we, beat_sel;
    logic [WORD_AW-1:0]       ram_addr;
    logic                     unused_bits;

    assign app_addr    = app.i_app_addr;
    assign burst_idx   = app_addr[RAM_ADDR_BITS+2:3];
    assign unused_bits = ^{app_addr, fifo_empty};

    assign app_rdy  = calib_q && !app.i_stall && (state_q == ST_IDLE);
    assign cmd_fire = app.i_app_en && app_rdy;
    assign beat_sel = (state_q == ST_WR_BEAT1) || (state_q == ST_RD_BEAT1);
    assign ram_addr = {idx_q, beat_sel};

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_d      = err_q;
        fifo_pop   = 1'b0;
        ram_we     = 1'b0;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_fire) begin
                    if (app.i_app_cmd == CMD_WR) begin
                        idx_d   = burst_idx;
                        state_d = ST_WR_WAIT;
                    end else if (app.i_app_cmd == CMD_RD) begin
                        idx_d   = burst_idx;
                        state_d = ST_RD_BEAT0;
                    end else begin
                        err_d[ERR_CMD] = 1'b1;
                    end
                end
            end
            ST_WR_WAIT: begin
                if (fifo_count >= CNT_W'(2)) begin
                    state_d = ST_WR_BEAT0;
                end
            end
            ST_WR_BEAT0: begin
                fifo_pop = 1'b1;
                ram_we   = 1'b1;
                if (fifo_head.last) begin
                    err_d[ERR_WDF_END] = 1'b1;
                end
                state_d = ST_WR_BEAT1;
            end
            ST_WR_BEAT1: begin
                fifo_pop = 1'b1;
                ram_we   = 1'b1;
                if (!fifo_head.last) begin
                    err_d[ERR_WDF_END] = 1'b1;
                end
                state_d = ST_IDLE;
            end
            ST_RD_BEAT0: begin
                rd_valid_d = 1'b1;
                state_d    = ST_RD_BEAT1;
            end
            ST_RD_BEAT1: begin
                rd_valid_d = 1'b1;
                rd_last_d  = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            calib_cnt_q <= '0;
            calib_q     <= 1'b0;
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            err_q       <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            calib_cnt_q <= calib_cnt_d;
            calib_q     <= calib_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    // ---------------- burst RAM ----------------
    // Write port takes the FIFO head with per-byte enables (mask bit = keep);
    // read port has a registered output. The write is suppressed while rst is
    // high so a reset landing on beat1 leaves at most beat0 updated.
    logic [31:0] mem [2**WORD_AW];
    logic [31:0] ram_rdata;

    always_ff @(posedge clk) begin
        for (int unsigned b = 0; b < 4; b++) begin
            if (ram_we && !rst && !fifo_head.mask[b]) begin
                mem[ram_addr][8*b +: 8] <= fifo_head.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        ram_rdata <= mem[ram_addr];
    end

    // ---------------- read latency pipe ----------------
    // The RAM output register plus its tag already account for two cycles
    // of latency; the remainder is a plain shift register.
    rd_beat_t rd_head, rd_out;

    assign rd_head = {rd_valid_q, rd_last_q, ram_rdata};

    generate
        if (PIPE_STAGES == 0) begin : g_no_pipe
            assign rd_out = rd_head;
        end else begin : g_pipe
            rd_beat_t pipe_q [PIPE_STAGES];
            rd_beat_t pipe_d [PIPE_STAGES];

            always_comb begin
                pipe_d[0] = rd_head;
                for (int unsigned i = 1; i < PIPE_STAGES; i++) begin
                    pipe_d[i] = pipe_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int unsigned i = 0; i < PIPE_STAGES; i++) begin
                        pipe_q[i] <= '0;
                    end
                end else begin
                    pipe_q <= pipe_d;
                end
            end

            assign rd_out = pipe_q[PIPE_STAGES-1];
        end
    endgenerate

    // ---------------- outputs ----------------
    assign app.o_init_calib_complete = calib_q;
    assign app.o_app_rdy             = app_rdy;
    assign app.o_app_wdf_rdy         = wdf_rdy;
    assign app.o_app_rd_data_valid   = rd_out.valid;
    assign app.o_app_rd_data_end     = rd_out.valid && rd_out.last;
    assign app.o_app_rd_data         = rd_out.valid ? rd_out.data : '0;
    assign app.o_err                 = err_q;

endmodule

// File: tb/tb_ddr3_app_responder.sv
// Directed bench for ddr3_app_responder: calibration, write/read with
// latency, byte masks, data-before-command, back-to-back spacing, stall and
// address aliasing, error flags and reset during a read.
module tb_ddr3_app_responder;
    import ddr3_app_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ddr3_app_responder_if #(.MEM_ADDR_DEPTH(28)) app ();

    ddr3_app_responder #(
        .MEM_ADDR_DEPTH (28),
        .RAM_ADDR_BITS  (10),
        .CALIB_CYCLES   (64),
        .READ_LATENCY   (8),
        .WDF_DEPTH      (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .app (app)
    );

    int checks = 0;
    int passes = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] mon_data [$];
    logic        mon_end  [$];
    int unsigned mon_cyc  [$];

    always @(negedge clk) begin
        if (app.o_app_rd_data_valid === 1'b1) begin
            mon_data.push_back(app.o_app_rd_data);
            mon_end.push_back(app.o_app_rd_data_end);
            mon_cyc.push_back(cyc);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    task automatic push_beat(input logic [31:0] d, input logic [3:0] m, input logic e);
        int n = 0;
        @(negedge clk);
        app.i_app_wdf_wren = 1'b1;
        app.i_app_wdf_data = d;
        app.i_app_wdf_mask = m;
        app.i_app_wdf_end  = e;
        #1;
        while (app.o_app_wdf_rdy !== 1'b1 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (app.o_app_wdf_rdy !== 1'b1) begin
            checks++;
            $display("FAIL wdf_push_timeout: wdf_rdy=%b required 1", app.o_app_wdf_rdy);
        end
        @(posedge clk); #1;
        app.i_app_wdf_wren = 1'b0;
    endtask

    task automatic issue_cmd(input logic [2:0] cmd, input logic [27:0] addr,
                             output int unsigned t);
        int n = 0;
        @(negedge clk);
        app.i_app_en   = 1'b1;
        app.i_app_cmd  = cmd;
        app.i_app_addr = addr;
        #1;
        while (app.o_app_rdy !== 1'b1 && n < 200) begin
            @(negedge clk); #1; n++;
        end
        if (app.o_app_rdy !== 1'b1) begin
            checks++;
            $display("FAIL cmd_accept_timeout: app_rdy=%b required 1", app.o_app_rdy);
        end
        t = cyc;
        @(posedge clk); #1;
        app.i_app_en = 1'b0;
    endtask

    task automatic write_burst(input logic [27:0] addr, input logic [31:0] d0,
                               input logic [31:0] d1, input logic [3:0] m0,
                               input logic [3:0] m1);
        int unsigned t;
        push_beat(d0, m0, 1'b0);
        push_beat(d1, m1, 1'b1);
        issue_cmd(CMD_WR, addr, t);
    endtask

    task automatic read_burst(input logic [27:0] addr,
                              output logic [31:0] d0, output logic [31:0] d1,
                              output logic e0, output logic e1,
                              output int l0, output int l1);
        int unsigned t;
        int n = 0;
        mon_data.delete(); mon_end.delete(); mon_cyc.delete();
        issue_cmd(CMD_RD, addr, t);
        while (mon_data.size() < 2 && n < 40) begin
            @(negedge clk); n++;
        end
        #1;
        if (mon_data.size() < 2) begin
            checks++;
            $display("FAIL read_timeout: beats=%0d required 2", mon_data.size());
            d0 = '0; d1 = '0; e0 = 1'b0; e1 = 1'b0; l0 = 0; l1 = 0;
        end else begin
            d0 = mon_data[0]; d1 = mon_data[1];
            e0 = mon_end[0];  e1 = mon_end[1];
            l0 = int'(mon_cyc[0] - t);
            l1 = int'(mon_cyc[1] - t);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        logic [2:0] exp3, obs3;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({app.o_init_calib_complete, app.o_app_rdy, app.o_app_wdf_rdy,
             app.o_app_rd_data_valid, app.o_app_rd_data_end} !== 5'b0)
            $display("FAIL reset_flags: got %b required 00000",
                     {app.o_init_calib_complete, app.o_app_rdy, app.o_app_wdf_rdy,
                      app.o_app_rd_data_valid, app.o_app_rd_data_end});
        else passes++;
        checks++;
        if (app.o_app_rd_data !== 32'h0)
            $display("FAIL reset_rd_data: got %h required 00000000", app.o_app_rd_data);
        else passes++;
        checks++;
        if (app.o_err !== 2'b00)
            $display("FAIL reset_err: got %b required 00", app.o_err);
        else passes++;

        // cycle 0 is the first cycle with rst low
        rst = 1'b0;
        for (int c = 0; c <= 64; c++) begin
            if (c != 0) begin
                @(negedge clk); #1;
            end
            exp3 = (c >= 64) ? 3'b111 : 3'b000;
            obs3 = {app.o_init_calib_complete, app.o_app_rdy, app.o_app_wdf_rdy};
            checks++;
            if (obs3 !== exp3)
                $display("FAIL calib_cycle_%0d: {calib,rdy,wdf_rdy}=%b required %b", c, obs3, exp3);
            else passes++;
        end
    endtask

    task automatic test_write_read;
        logic [31:0] d0, d1;
        logic e0, e1;
        int l0, l1;
        write_burst(28'h40, 32'h11223344, 32'h55667788, 4'h0, 4'h0);
        read_burst(28'h40, d0, d1, e0, e1, l0, l1);
        checks++; if (d0 !== 32'h11223344) $display("FAIL wr_rd_beat0: got %h required 11223344", d0); else passes++;
        checks++; if (d1 !== 32'h55667788) $display("FAIL wr_rd_beat1: got %h required 55667788", d1); else passes++;
        checks++; if (l0 !== 8) $display("FAIL rd_latency_beat0: got %0d required 8", l0); else passes++;
        checks++; if (l1 !== 9) $display("FAIL rd_latency_beat1: got %0d required 9", l1); else passes++;
        checks++; if (e0 !== 1'b0) $display("FAIL rd_end_beat0: got %b required 0", e0); else passes++;
        checks++; if (e1 !== 1'b1) $display("FAIL rd_end_beat1: got %b required 1", e1); else passes++;
    endtask

    task automatic test_back_to_back;
        int unsigned t1, t2;
        logic [31:0] d0, d1;
        logic e0, e1;
        int l0, l1;
        mon_data.delete(); mon_end.delete(); mon_cyc.delete();
        issue_cmd(CMD_RD, 28'h40, t1);
        issue_cmd(CMD_RD, 28'h40, t2);
        checks++;
        if (t2 - t1 !== 3) $display("FAIL read_spacing: got %0d required 3", t2 - t1); else passes++;
        repeat (15) @(negedge clk);
        #1;
        checks++;
        if (mon_data.size() !== 4) $display("FAIL b2b_read_beats: got %0d required 4", mon_data.size()); else passes++;

        push_beat(32'hAAAA0001, 4'h0, 1'b0);
        push_beat(32'hAAAA0002, 4'h0, 1'b1);
        push_beat(32'hBBBB0001, 4'h0, 1'b0);
        push_beat(32'hBBBB0002, 4'h0, 1'b1);
        issue_cmd(CMD_WR, 28'h48, t1);
        issue_cmd(CMD_WR, 28'h50, t2);
        checks++;
        if (t2 - t1 !== 4) $display("FAIL write_spacing: got %0d required 4", t2 - t1); else passes++;
        read_burst(28'h50, d0, d1, e0, e1, l0, l1);
        checks++;
        if ({d0, d1} !== {32'hBBBB0001, 32'hBBBB0002})
            $display("FAIL b2b_write_data: got %h_%h required bbbb0001_bbbb0002", d0, d1);
        else passes++;
    endtask

    task automatic test_byte_mask;
        logic [31:0] d0, d1;
        logic e0, e1;
        int l0, l1;
        write_burst(28'h80, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'h0, 4'h0);
        write_burst(28'h80, 32'h00000000, 32'h00000000, 4'b0101, 4'b1010);
        read_burst(28'h80, d0, d1, e0, e1, l0, l1);
        checks++; if (d0 !== 32'h00FF00FF) $display("FAIL mask_0101: got %h required 00ff00ff", d0); else passes++;
        checks++; if (d1 !== 32'hFF00FF00) $display("FAIL mask_1010: got %h required ff00ff00", d1); else passes++;
    endtask

    task automatic test_data_first;
        int unsigned t [4];
        logic [31:0] d0, d1, e_0, e_1;
        logic e0, e1;
        int l0, l1;
        for (int b = 0; b < 4; b++) begin
            push_beat(32'hC0DE0000 + 32'(2*b), 4'h0, 1'b0);
            push_beat(32'hC0DE0000 + 32'(2*b+1), 4'h0, 1'b1);
        end
        checks++;
        if (app.o_app_wdf_rdy !== 1'b0) $display("FAIL wdf_full: wdf_rdy=%b required 0", app.o_app_wdf_rdy); else passes++;
        for (int b = 0; b < 4; b++) issue_cmd(CMD_WR, 28'h100 + 28'(8*b), t[b]);
        for (int b = 1; b < 4; b++) begin
            checks++;
            if (t[b] - t[b-1] !== 4)
                $display("FAIL buffered_write_spacing_%0d: got %0d required 4", b, t[b] - t[b-1]);
            else passes++;
        end
        @(negedge clk); #1;
        checks++;
        if (app.o_app_wdf_rdy !== 1'b1) $display("FAIL wdf_rdy_return: wdf_rdy=%b required 1", app.o_app_wdf_rdy); else passes++;
        for (int b = 0; b < 4; b++) begin
            read_burst(28'h100 + 28'(8*b), d0, d1, e0, e1, l0, l1);
            e_0 = 32'hC0DE0000 + 32'(2*b);
            e_1 = 32'hC0DE0000 + 32'(2*b+1);
            checks++;
            if ({d0, d1} !== {e_0, e_1})
                $display("FAIL data_first_burst_%0d: got %h_%h required %h_%h", b, d0, d1, e_0, e_1);
            else passes++;
        end
    endtask

    task automatic test_stall_alias;
        int unsigned t;
        int bad = 0;
        logic [31:0] d0, d1;
        logic e0, e1;
        int l0, l1;
        @(negedge clk);
        app.i_stall = 1'b1;
        push_beat(32'hA11A0000, 4'h0, 1'b0);
        push_beat(32'hA11A0001, 4'h0, 1'b1);
        for (int b = 1; b < 4; b++) begin
            push_beat(32'hBEEF0000 + 32'(2*b), 4'h0, 1'b0);
            push_beat(32'hBEEF0000 + 32'(2*b+1), 4'h0, 1'b1);
        end
        @(negedge clk);
        app.i_app_en   = 1'b1;
        app.i_app_cmd  = CMD_WR;
        app.i_app_addr = 28'h2000;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (app.o_app_rdy !== 1'b0 || app.o_app_wdf_rdy !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) $display("FAIL stall_hold: %0d cycles with rdy or wdf_rdy high, required 0", bad); else passes++;
        app.i_stall = 1'b0;
        #1;
        checks++;
        if (app.o_app_rdy !== 1'b1) $display("FAIL stall_release: app_rdy=%b required 1", app.o_app_rdy); else passes++;
        @(posedge clk); #1;
        app.i_app_en = 1'b0;
        for (int b = 1; b < 4; b++) issue_cmd(CMD_WR, 28'h200 + 28'(8*b), t);
        read_burst(28'h0, d0, d1, e0, e1, l0, l1);
        checks++;
        if ({d0, d1} !== {32'hA11A0000, 32'hA11A0001})
            $display("FAIL alias_burst0: got %h_%h required a11a0000_a11a0001", d0, d1);
        else passes++;
        read_burst(28'h218, d0, d1, e0, e1, l0, l1);
        checks++;
        if ({d0, d1} !== {32'hBEEF0006, 32'hBEEF0007})
            $display("FAIL stall_queued_burst: got %h_%h required beef0006_beef0007", d0, d1);
        else passes++;
    endtask

    task automatic test_errors;
        int unsigned t;
        logic [31:0] d0, d1;
        logic e0, e1;
        int l0, l1;
        issue_cmd(3'b010, 28'h40, t);
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (app.o_err !== 2'b01) $display("FAIL bad_cmd_err: got %b required 01", app.o_err); else passes++;
        read_burst(28'h40, d0, d1, e0, e1, l0, l1);
        checks++;
        if ({d0, d1} !== {32'h11223344, 32'h55667788})
            $display("FAIL bad_cmd_ram: got %h_%h required 11223344_55667788", d0, d1);
        else passes++;
        push_beat(32'h12345678, 4'h0, 1'b1);
        push_beat(32'h9ABCDEF0, 4'h0, 1'b0);
        issue_cmd(CMD_WR, 28'h300, t);
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (app.o_err !== 2'b11) $display("FAIL wdf_end_err: got %b required 11", app.o_err); else passes++;
    endtask

    task automatic test_reset_mid_read;
        int unsigned t;
        mon_data.delete(); mon_end.delete(); mon_cyc.delete();
        issue_cmd(CMD_RD, 28'h40, t);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        #1;
        checks++;
        if (mon_data.size() !== 0) $display("FAIL reset_read_discard: beats=%0d required 0", mon_data.size()); else passes++;
        checks++;
        if (app.o_err !== 2'b00) $display("FAIL reset_err_clear: got %b required 00", app.o_err); else passes++;
        checks++;
        if (app.o_init_calib_complete !== 1'b0)
            $display("FAIL reset_calib_restart: got %b required 0", app.o_init_calib_complete);
        else passes++;
    endtask

    initial begin
        app.i_app_en       = 1'b0;
        app.i_app_cmd      = 3'b000;
        app.i_app_addr     = '0;
        app.i_app_wdf_wren = 1'b0;
        app.i_app_wdf_mask = 4'h0;
        app.i_app_wdf_end  = 1'b0;
        app.i_app_wdf_data = '0;
        app.i_stall        = 1'b0;

        test_reset();
        test_write_read();
        test_back_to_back();
        test_byte_mask();
        test_data_first();
        test_stall_alias();
        test_errors();
        test_reset_mid_read();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
